// File: rtl/handshake_fork_tx.sv
// Ready/valid fork: accepts one word upstream and broadcasts it to N lanes with per-lane handshakes.
// Define HANDSHAKE_FORK_TX_SVA_EN to compile in protocol assertions.
module handshake_fork_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 3
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [N-1:0]     lane_en,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_orr,
  output logic             out_andr,
  output logic             busy
);

  logic [N-1:0]     pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             orr_q, orr_d;
  logic             andr_q, andr_d;
  logic [N-1:0]     remain;
  logic             accept;

  // Lanes still waiting after this cycle's completions; only those block a new word.
  assign remain   = pend_q & ~out_ready;
  assign in_ready = (remain == '0);
  assign accept   = in_valid & in_ready;

  always_comb begin
    pend_d = remain;
    data_d = data_q;
    orr_d  = orr_q;
    andr_d = andr_q;
    if (accept) begin
      pend_d = lane_en;
      data_d = in_data;
      orr_d  = |in_data;
      andr_d = &in_data;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      pend_q <= '0;
      data_q <= '0;
      orr_q  <= 1'b0;
      andr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      orr_q  <= orr_d;
      andr_q <= andr_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = data_q;
  assign out_orr   = orr_q;
  assign out_andr  = andr_q;
  assign busy      = |pend_q;

`ifdef HANDSHAKE_FORK_TX_SVA_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_lane_sva
    a_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
      out_valid[gi] && !out_ready[gi] |=> out_valid[gi] && $stable(out_data));
  end

  a_ready: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    in_ready |-> ((out_valid & ~out_ready) == '0));

  a_flags: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    (out_orr === |out_data) && (out_andr === &out_data));

  a_known: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    !$isunknown(out_valid) && !$isunknown(in_ready));
`else
`endif

endmodule

// File: tb/tb_handshake_fork_tx.sv
// Self-checking bench for handshake_fork_tx: directed cases then a randomized run
// checked against per-lane delivery queues.
module tb_handshake_fork_tx;
  localparam int unsigned W = 4;
  localparam int unsigned L = 3;
  localparam int unsigned NumWords = 1000;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [L-1:0] lane_en;
  logic [L-1:0] out_valid;
  logic [L-1:0] out_ready;
  logic [W-1:0] out_data;
  logic         out_orr;
  logic         out_andr;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each lane owns a queue of words it has yet to take.
  logic [W-1:0] lane_q [L][$];
  logic [W-1:0] model_data;
  int           tx_cnt [L];
  int           rx_cnt [L];
  int           words_sent;

  handshake_fork_tx #(.WIDTH(W), .N(L)) u_dut (
    .CLK       (clk),
    .ASYNCRESET(rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lane_en   (lane_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_orr   (out_orr),
    .out_andr  (out_andr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input logic [L-1:0] v, input logic [W-1:0] d, input logic rdy);
    check_eq("out_valid", 32'(out_valid), 32'(v));
    check_eq("out_data", 32'(out_data), 32'(d));
    check_eq("out_orr", 32'(out_orr), 32'(d != 0));
    check_eq("out_andr", 32'(out_andr), 32'(d == {W{1'b1}}));
    check_eq("in_ready", 32'(in_ready), 32'(rdy));
    check_eq("busy", 32'(busy), 32'(v != 0));
  endtask

  // One randomized cycle: drive, compare against the model, then advance the model.
  task automatic rand_cycle(input bit drain);
    logic         exp_ready;
    logic [L-1:0] exp_valid;
    in_valid  = drain ? 1'b0 : ($urandom_range(3) != 0);
    in_data   = W'($urandom);
    lane_en   = L'($urandom);
    out_ready = drain ? {L{1'b1}} : L'($urandom);
    #1;
    exp_ready = 1'b1;
    for (int i = 0; i < L; i++) begin
      exp_valid[i] = (lane_q[i].size() != 0);
      if (exp_valid[i] && !out_ready[i]) exp_ready = 1'b0;
    end
    check_outs(exp_valid, model_data, exp_ready);
    for (int i = 0; i < L; i++) begin
      if (exp_valid[i] && out_ready[i]) begin
        check_eq($sformatf("lane%0d_word", i), 32'(out_data), 32'(lane_q[i][0]));
        void'(lane_q[i].pop_front());
        rx_cnt[i]++;
      end
    end
    if (in_valid && exp_ready) begin
      model_data = in_data;
      words_sent++;
      for (int i = 0; i < L; i++) begin
        if (lane_en[i]) begin
          lane_q[i].push_back(in_data);
          tx_cnt[i]++;
        end
      end
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    lane_en   = '0;
    out_ready = '0;
    #12;
    rst = 1'b0;
    tick();
    check_outs(3'b000, 4'h0, 1'b1);

    // Back-to-back words with all lanes ready: no bubble.
    in_valid = 1'b1; in_data = 4'hF; lane_en = 3'b111; out_ready = 3'b111;
    #1 check_eq("b2b_ready0", 32'(in_ready), 32'd1);
    tick();
    check_outs(3'b111, 4'hF, 1'b1);
    in_data = 4'h3;
    tick();
    check_outs(3'b111, 4'h3, 1'b1);
    in_valid = 1'b0;
    tick();
    check_outs(3'b000, 4'h3, 1'b1);

    // Lanes complete out of order.
    in_valid = 1'b1; in_data = 4'hA; lane_en = 3'b111; out_ready = 3'b000;
    tick();
    in_valid = 1'b0; out_ready = 3'b001;
    #1 check_outs(3'b111, 4'hA, 1'b0);
    tick();
    out_ready = 3'b100;
    #1 check_outs(3'b110, 4'hA, 1'b0);
    tick();
    out_ready = 3'b010;
    #1 check_outs(3'b010, 4'hA, 1'b1);
    tick();
    out_ready = 3'b000;
    #1 check_outs(3'b000, 4'hA, 1'b1);

    // Word with no lanes enabled is dropped but still captured.
    in_valid = 1'b1; in_data = 4'h5; lane_en = 3'b000;
    tick();
    in_valid = 1'b0;
    #1 check_outs(3'b000, 4'h5, 1'b1);

    // Reset mid-transaction takes effect before the next edge.
    in_valid = 1'b1; in_data = 4'h6; lane_en = 3'b011; out_ready = 3'b000;
    tick();
    in_valid = 1'b0;
    #1 check_outs(3'b011, 4'h6, 1'b0);
    rst = 1'b1;
    #1 check_outs(3'b000, 4'h0, 1'b1);
    #1 rst = 1'b0;
    tick();
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);

    // Randomized run against the lane-queue model.
    model_data = '0;
    words_sent = 0;
    for (int i = 0; i < L; i++) begin
      tx_cnt[i] = 0;
      rx_cnt[i] = 0;
    end
    for (int c = 0; c < 20000 && words_sent < NumWords; c++) rand_cycle(1'b0);
    check_eq("word_budget", 32'(words_sent), 32'(NumWords));
    for (int c = 0; c < 4; c++) rand_cycle(1'b1);
    for (int i = 0; i < L; i++) begin
      check_eq($sformatf("lane%0d_left", i), 32'(lane_q[i].size()), 32'd0);
      check_eq($sformatf("lane%0d_count", i), 32'(rx_cnt[i]), 32'(tx_cnt[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
